c_register_loader: RTL and testbench

Stream-to-word loader that assembles `BITS`-wide words from a narrow valid/ready chunk stream. It drives a register's `in`/`save` pair: `save` is a single-cycle pulse, and `out` holds the committed word. The block sits between the byte-wide load/debug channel and any `BITS`-wide architectural register, so registers can be preloaded without a full-width bus.

---
 rtl/c_register_loader.sv | 126 ++++++++++++
 tb/tb_c_register_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/c_register_loader.sv
// Assembles BITS-wide words from a CHUNK-wide valid/ready stream and commits them with a one-cycle save strobe.
// Optional odd-parity checking on each chunk is enabled by defining C_REGISTER_LOADER_PARITY_EN.
module c_register_loader #(
    parameter int unsigned BITS  = 16,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [CHUNK-1:0] in_data,
    input  logic             in_par,
    output logic             in_ready,
    output logic             save,
    output logic [BITS-1:0]  out,
    output logic             busy,
    output logic             err
);
    localparam int unsigned N     = BITS / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [BITS-1:0]  acc, acc_nxt;
    logic [BITS-1:0]  out_q, out_nxt;
    logic [BITS-1:0]  word_c;
    logic             save_q, save_nxt;
    logic             busy_q, busy_nxt;
    logic             bad_q, bad_nxt;
    logic             err_q, err_nxt;
    logic             accept;
    logic             chunk_bad;

`ifdef C_REGISTER_LOADER_PARITY_EN
    // A chunk plus its parity bit must carry an odd number of ones.
    assign chunk_bad = ~(^{in_data, in_par});
`else
    logic unused_par;
    assign unused_par = in_par;
    assign chunk_bad  = 1'b0;
`endif

    // Ready is a function of state, abort and reset only, so no loop back through in_valid.
    assign in_ready = rst && !abort && (state != COMMIT);
    assign accept   = in_valid && in_ready;

    assign save = save_q;
    assign busy = busy_q;
    assign out  = out_q;
    assign err  = err_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        out_nxt   = out_q;
        bad_nxt   = bad_q;
        err_nxt   = err_q;
        word_c    = acc;
        word_c[int'(cnt) * int'(CHUNK) +: CHUNK] = in_data;

        case (state)
            IDLE, FILL: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                    bad_nxt   = 1'b0;
                end else if (accept) begin
                    err_nxt = err_q | chunk_bad;
                    if (cnt == LAST) begin
                        cnt_nxt = '0;
                        acc_nxt = '0;
                        bad_nxt = 1'b0;
                        // A word with any bad chunk is dropped without a save.
                        if (bad_q || chunk_bad) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = COMMIT;
                            out_nxt   = word_c;
                        end
                    end else begin
                        state_nxt = FILL;
                        cnt_nxt   = cnt + CNT_W'(1);
                        acc_nxt   = word_c;
                        bad_nxt   = bad_q | chunk_bad;
                    end
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        save_nxt = (state_nxt == COMMIT);
        busy_nxt = (state_nxt == FILL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            out_q  <= '0;
            save_q <= 1'b0;
            busy_q <= 1'b0;
            bad_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            acc    <= acc_nxt;
            out_q  <= out_nxt;
            save_q <= save_nxt;
            busy_q <= busy_nxt;
            bad_q  <= bad_nxt;
            err_q  <= err_nxt;
        end
    end
endmodule

// File: tb/tb_c_register_loader.sv
// Directed testbench for c_register_loader (BITS=16, CHUNK=8): per-cycle vector table plus
// hand-written throughput and parity sequences.
module tb_c_register_loader;
    logic        clk;
    logic        rst;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_par;
    logic        in_ready;
    logic        save;
    logic [15:0] out;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    c_register_loader #(.BITS(16), .CHUNK(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_par   (in_par),
        .in_ready (in_ready),
        .save     (save),
        .out      (out),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        abt;
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic        sav;
        logic        bsy;
        logic [15:0] o;
    } vec_t;

    vec_t tv[28];

    function automatic vec_t mk(input logic r, input logic a, input logic v, input logic [7:0] d,
                                input logic rd, input logic s, input logic b, input logic [15:0] o);
        vec_t t;
        t.rst = r; t.abt = a; t.vld = v; t.dat = d;
        t.rdy = rd; t.sav = s; t.bsy = b; t.o = o;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [7:0]  ch[6];
    logic [15:0] words[3];
    int          idx;
    int          nsave;
    int          save_cyc[3];
    logic        acc_now;

    initial begin
        rst = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_par = 1'b0;

        //           rst abt vld dat    rdy sav bsy out
        tv[0]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 16'h0000);
        tv[1]  = mk(1, 0, 1, 8'h34, 1, 0, 0, 16'h0000);
        tv[2]  = mk(1, 0, 1, 8'h12, 1, 0, 1, 16'h0000);
        tv[3]  = mk(1, 0, 1, 8'h99, 0, 1, 0, 16'h1234);
        tv[4]  = mk(1, 0, 0, 8'h00, 1, 0, 0, 16'h1234);
        tv[5]  = mk(1, 0, 1, 8'hAA, 1, 0, 0, 16'h1234);
        tv[6]  = mk(1, 0, 0, 8'hFF, 1, 0, 1, 16'h1234);
        tv[7]  = mk(1, 0, 0, 8'hFF, 1, 0, 1, 16'h1234);
        tv[8]  = mk(1, 0, 0, 8'h00, 1, 0, 1, 16'h1234);
        tv[9]  = mk(1, 0, 1, 8'h55, 1, 0, 1, 16'h1234);
        tv[10] = mk(1, 0, 0, 8'h00, 0, 1, 0, 16'h55AA);
        tv[11] = mk(1, 0, 0, 8'h00, 1, 0, 0, 16'h55AA);
        tv[12] = mk(1, 0, 1, 8'h11, 1, 0, 0, 16'h55AA);
        tv[13] = mk(1, 1, 1, 8'h22, 0, 0, 1, 16'h55AA);
        tv[14] = mk(1, 0, 1, 8'h33, 1, 0, 0, 16'h55AA);
        tv[15] = mk(1, 0, 1, 8'h44, 1, 0, 1, 16'h55AA);
        tv[16] = mk(1, 0, 0, 8'h00, 0, 1, 0, 16'h4433);
        tv[17] = mk(1, 1, 0, 8'h00, 0, 0, 0, 16'h4433);
        tv[18] = mk(1, 0, 1, 8'hC3, 1, 0, 0, 16'h4433);
        tv[19] = mk(1, 0, 1, 8'h3C, 1, 0, 1, 16'h4433);
        tv[20] = mk(1, 1, 1, 8'h77, 0, 1, 0, 16'h3CC3);
        tv[21] = mk(1, 0, 0, 8'h00, 1, 0, 0, 16'h3CC3);
        tv[22] = mk(1, 0, 1, 8'h77, 1, 0, 0, 16'h3CC3);
        tv[23] = mk(0, 0, 1, 8'h88, 0, 0, 1, 16'h3CC3);
        tv[24] = mk(1, 0, 1, 8'h01, 1, 0, 0, 16'h0000);
        tv[25] = mk(1, 0, 1, 8'h02, 1, 0, 1, 16'h0000);
        tv[26] = mk(1, 0, 0, 8'h00, 0, 1, 0, 16'h0201);
        tv[27] = mk(1, 0, 0, 8'h00, 1, 0, 0, 16'h0201);

        // Outputs checked at each vector reflect the state left by the previous edges.
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            rst      = tv[i].rst;
            abort    = tv[i].abt;
            in_valid = tv[i].vld;
            in_data  = tv[i].dat;
            in_par   = ~(^tv[i].dat);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tv[i].rdy));
            chk($sformatf("v%0d save", i),     32'(save),     32'(tv[i].sav));
            chk($sformatf("v%0d busy", i),     32'(busy),     32'(tv[i].bsy));
            chk($sformatf("v%0d out", i),      32'(out),      32'(tv[i].o));
            chk($sformatf("v%0d err", i),      32'(err),      32'h0);
        end

        // Back-to-back words with in_valid held high.
        ch[0] = 8'h01; ch[1] = 8'h02; ch[2] = 8'h03; ch[3] = 8'h04; ch[4] = 8'h05; ch[5] = 8'h06;
        words[0] = 16'h0201; words[1] = 16'h0403; words[2] = 16'h0605;
        idx = 0; nsave = 0;
        abort = 1'b0; rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            in_valid = (idx < 6);
            in_data  = (idx < 6) ? ch[idx] : 8'h00;
            in_par   = ~(^in_data);
            #1;
            if (save) begin
                if (nsave < 3) begin
                    save_cyc[nsave] = c;
                    chk($sformatf("stream word%0d out", nsave), 32'(out), 32'(words[nsave]));
                end
                chk($sformatf("stream word%0d ready during save", nsave), 32'(in_ready), 32'h0);
                nsave++;
            end
            acc_now = in_valid && in_ready;
            @(posedge clk);
            if (acc_now) idx++;
        end
        chk("stream save count", 32'(nsave), 32'd3);
        if (nsave >= 3) begin
            chk("stream first save cycle", 32'(save_cyc[0]), 32'd2);
            chk("stream spacing 0-1", 32'(save_cyc[1] - save_cyc[0]), 32'd3);
            chk("stream spacing 1-2", 32'(save_cyc[2] - save_cyc[1]), 32'd3);
        end

        // Word with a bad-parity first chunk.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h01; in_par = 1'b1;
        #1;
        chk("par bad0 ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_data = 8'h02; in_par = 1'b0;
        #1;
        chk("par bad0 busy", 32'(busy), 32'h1);
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'h00; in_par = 1'b0;
        #1;
`ifdef C_REGISTER_LOADER_PARITY_EN
        chk("par bad word save", 32'(save), 32'h0);
        chk("par bad word out", 32'(out), 32'h0605);
        chk("par bad word err", 32'(err), 32'h1);
        chk("par bad word ready", 32'(in_ready), 32'h1);
        chk("par bad word busy", 32'(busy), 32'h0);
        @(negedge clk);
        #1;
        chk("par bad word save later", 32'(save), 32'h0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h10; in_par = 1'b0;
        @(negedge clk);
        in_data = 8'h20; in_par = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'h00;
        #1;
        chk("par good word save", 32'(save), 32'h1);
        chk("par good word out", 32'(out), 32'h2010);
        chk("par good word err sticky", 32'(err), 32'h1);
`else
        chk("nopar word save", 32'(save), 32'h1);
        chk("nopar word out", 32'(out), 32'h0201);
        chk("nopar word err", 32'(err), 32'h0);
`endif
        @(negedge clk);
        #1;
        chk("final save low", 32'(save), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
